// File: rtl/for_loop_pkg.sv
// -----------------------------------------------------------------------------
// for_loop_pkg
// Shared types and helpers for the for_loop_counter block.
//   state_e     : controller states (IDLE, RUN, DONE)
//   loop_cfg_t  : loop configuration latched when a go request is accepted
//   loop_cond() : loop-continue test (idx < limit going up, idx > limit going
//                 down), unsigned
// The struct and helper are sized by LOOP_WIDTH / LOOP_STEP_W. The top-level
// parameter defaults follow these values, so a different width is obtained by
// changing it here.
// -----------------------------------------------------------------------------
package for_loop_pkg;

  localparam int LOOP_WIDTH  = 4;
  localparam int LOOP_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [LOOP_WIDTH-1:0]  start;
    logic [LOOP_WIDTH-1:0]  limit;
    logic [LOOP_STEP_W-1:0] step;
    logic                   down;
    logic                   rpt;
  } loop_cfg_t;

  function automatic logic loop_cond(input logic [LOOP_WIDTH-1:0] idx,
                                     input logic [LOOP_WIDTH-1:0] limit,
                                     input logic                  down);
    return down ? (idx > limit) : (idx < limit);
  endfunction

endpackage

// File: rtl/for_loop_counter_alu.sv
// -----------------------------------------------------------------------------
// loop_step_alu
// Purely combinational step unit of the loop iterator. Advances the index by
// the step magnitude in WIDTH+1 bits so that running off either end of the
// WIDTH-bit range is visible as bit WIDTH of the result.
//   idx   : current index
//   step  : unsigned step magnitude (zero-extended)
//   limit : exclusive loop bound
//   down  : 1 subtracts the step, 0 adds it
//   nxt   : low WIDTH bits of the advanced index
//   wrap  : carry (up) or borrow (down) out of WIDTH bits
//   cont  : advanced index is in range and still satisfies the loop condition
// -----------------------------------------------------------------------------
module loop_step_alu #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 4
) (
  input  logic [WIDTH-1:0]  idx,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  limit,
  input  logic              down,
  output logic [WIDTH-1:0]  nxt,
  output logic              wrap,
  output logic              cont
);

  logic [WIDTH:0] step_ext;
  logic [WIDTH:0] sum;

  // Both operands are below 2**WIDTH, so an underflowing subtraction always
  // lands with bit WIDTH set, exactly like an overflowing addition.
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum      = down ? ({1'b0, idx} - step_ext) : ({1'b0, idx} + step_ext);

  assign nxt  = sum[WIDTH-1:0];
  assign wrap = sum[WIDTH];
  assign cont = !wrap && (down ? (nxt > limit) : (nxt < limit));

endmodule

// File: rtl/for_loop_counter.sv
// -----------------------------------------------------------------------------
// for_loop_counter
// Hardware for-loop iterator. A go accepted in IDLE latches start/limit/step/
// direction/repeat and the block then emits one index per valid/ready beat.
// When the loop condition fails (or the index runs off the WIDTH-bit range)
// it pulses done for one cycle with the terminating index on final_value.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   cfg_*             : loop configuration, sampled on an accepted go
//   go                : start request (IDLE only); abort cancels any state
//   out_valid/ready   : index handshake, out_value is the current index
//   busy              : not IDLE
//   done, final_value : completion pulse and terminating index (held)
//   wrapped           : with done, loop ended by carry/borrow
//   err_step          : one-cycle pulse, go rejected because step was zero
// -----------------------------------------------------------------------------
module for_loop_counter
  import for_loop_pkg::*;
#(
  parameter int WIDTH  = LOOP_WIDTH,
  parameter int STEP_W = LOOP_STEP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cfg_start,
  input  logic [WIDTH-1:0]  cfg_limit,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              cfg_down,
  input  logic              cfg_repeat,
  input  logic              go,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_value,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  final_value,
  output logic              wrapped,
  output logic              err_step
);

  state_e            state_q, state_d;
  loop_cfg_t         cfg_q, cfg_d;
  logic [WIDTH-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0]  final_q, final_d;
  logic              wrapped_q, wrapped_d;
  logic              err_step_q, err_step_d;

  logic [WIDTH-1:0]  alu_nxt;
  logic              alu_wrap;
  logic              alu_cont;

  loop_step_alu #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_alu (
    .idx   (idx_q),
    .step  (cfg_q.step),
    .limit (cfg_q.limit),
    .down  (cfg_q.down),
    .nxt   (alu_nxt),
    .wrap  (alu_wrap),
    .cont  (alu_cont)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cfg_d      = cfg_q;
    idx_d      = idx_q;
    final_d    = final_q;
    wrapped_d  = 1'b0;
    err_step_d = 1'b0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            if (cfg_step == '0) begin
              // A zero step would never terminate; reject it outright.
              err_step_d = 1'b1;
            end else begin
              cfg_d = '{start: cfg_start, limit: cfg_limit, step: cfg_step,
                        down: cfg_down, rpt: cfg_repeat};
              idx_d = cfg_start;
              if (loop_cond(cfg_start, cfg_limit, cfg_down)) begin
                state_d = RUN;
              end else begin
                state_d = DONE;
                final_d = cfg_start;
              end
            end
          end
        end

        RUN: begin
          if (out_ready) begin
            if (alu_wrap) begin
              state_d   = DONE;
              final_d   = alu_nxt;
              wrapped_d = 1'b1;
            end else if (!alu_cont) begin
              state_d = DONE;
              final_d = alu_nxt;
            end else begin
              idx_d = alu_nxt;
            end
          end
        end

        DONE: begin
          if (cfg_q.rpt) begin
            // Restart from the latched start; a zero-trip config stays in
            // DONE and pulses done every cycle until aborted.
            idx_d = cfg_q.start;
            if (loop_cond(cfg_q.start, cfg_q.limit, cfg_q.down)) begin
              state_d = RUN;
            end else begin
              final_d = cfg_q.start;
            end
          end else begin
            state_d = IDLE;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      idx_q      <= '0;
      final_q    <= '0;
      wrapped_q  <= 1'b0;
      err_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      idx_q      <= idx_d;
      final_q    <= final_d;
      wrapped_q  <= wrapped_d;
      err_step_q <= err_step_d;
    end
  end

  assign out_valid   = (state_q == RUN);
  assign out_value   = idx_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign final_value = final_q;
  // wrapped_d defaults to 0, so the flop is only ever set for a DONE cycle.
  assign wrapped     = wrapped_q;
  assign err_step    = err_step_q;

endmodule

// File: tb/tb_for_loop_counter.sv
// -----------------------------------------------------------------------------
// tb_for_loop_counter
// Self-checking bench for for_loop_counter (WIDTH=4, STEP_W=4). Expected index
// sequences, final values and wrap flags come from an integer model of the
// for-loop rules; outputs are sampled and inputs driven on the falling edge.
// -----------------------------------------------------------------------------
module tb_for_loop_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cfg_start, cfg_limit, cfg_step;
  logic       cfg_down, cfg_repeat, go, abort, out_ready;
  logic       out_valid, busy, done, wrapped, err_step;
  logic [3:0] out_value, final_value;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int exp_fin;
  bit exp_wr;

  for_loop_counter #(.WIDTH(4), .STEP_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_start   (cfg_start),
    .cfg_limit   (cfg_limit),
    .cfg_step    (cfg_step),
    .cfg_down    (cfg_down),
    .cfg_repeat  (cfg_repeat),
    .go          (go),
    .abort       (abort),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .busy        (busy),
    .done        (done),
    .final_value (final_value),
    .wrapped     (wrapped),
    .err_step    (err_step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer model of the loop: list of emitted indices, terminating value and
  // whether the index left the 0..15 range.
  task automatic model(input int s, input int l, input int st, input bit dn);
    int i, n;
    exp_q.delete();
    i = s;
    if (!(dn ? (i > l) : (i < l))) begin
      exp_fin = i;
      exp_wr  = 1'b0;
      return;
    end
    forever begin
      exp_q.push_back(i);
      n = dn ? i - st : i + st;
      if (n < 0 || n > 15) begin
        exp_fin = n & 15;
        exp_wr  = 1'b1;
        return;
      end
      if (!(dn ? (n > l) : (n < l))) begin
        exp_fin = n;
        exp_wr  = 1'b0;
        return;
      end
      i = n;
    end
  endtask

  function automatic logic ready_pick(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;   // 1,0,0,1,0,0,...
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // One non-repeating loop: go, collect beats under the chosen ready pattern,
  // then check the completion cycle and the return to IDLE. With extra_go a
  // second go carrying a different config is issued while busy.
  task automatic run_loop(input logic [3:0] s, input logic [3:0] l,
                          input logic [3:0] st, input logic dn,
                          input int rmode, input bit extra_go);
    int   cyc, got;
    bit   stalled;
    logic [3:0] held;
    model(int'(s), int'(l), int'(st), dn);
    @(negedge clk);
    cfg_start = s; cfg_limit = l; cfg_step = st; cfg_down = dn; cfg_repeat = 1'b0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("first_valid", out_valid, exp_q.size() != 0);
    check("first_busy", busy, 1);
    cyc = 0; got = 0; stalled = 1'b0; held = '0;
    while (!done && cyc < 200) begin
      out_ready = ready_pick(rmode, cyc);
      if (extra_go && cyc == 1) begin
        go = 1'b1; cfg_start = ~s; cfg_step = st + 4'd1; cfg_down = ~dn;
      end else begin
        go = 1'b0; cfg_start = s; cfg_step = st; cfg_down = dn;
      end
      if (out_valid) begin
        if (stalled) check("hold_value", out_value, held);
        if (out_ready) begin
          check("beat_value", out_value, (got < exp_q.size()) ? exp_q[got] : 32'hDEAD);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = out_value;
        end
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    check("done_seen", done, 1);
    check("beat_count", got, exp_q.size());
    check("valid_in_done", out_valid, 0);
    check("final_value", final_value, exp_fin);
    check("wrapped", wrapped, exp_wr);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("wrapped_low", wrapped, 0);
    check("idle_busy", busy, 0);
    check("final_held", final_value, exp_fin);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cfg_start = '0; cfg_limit = '0; cfg_step = '0; cfg_down = 1'b0; cfg_repeat = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_err", err_step, 0);
    check("rst_value", out_value, 0);
    check("rst_final", final_value, 0);
    rst = 1'b0;

    // Directed loops from the plan.
    run_loop(4'd2,  4'd14, 4'd2, 1'b0, 0, 1'b0);
    run_loop(4'd2,  4'd14, 4'd2, 1'b0, 1, 1'b0);
    run_loop(4'd10, 4'd15, 4'd4, 1'b0, 0, 1'b0);
    run_loop(4'd9,  4'd2,  4'd3, 1'b1, 0, 1'b0);
    run_loop(4'd5,  4'd5,  4'd1, 1'b0, 0, 1'b0);
    run_loop(4'd1,  4'd0,  4'd3, 1'b1, 2, 1'b0);

    // Zero step: error pulse, stays idle, no done.
    @(negedge clk);
    cfg_start = 4'd1; cfg_limit = 4'd9; cfg_step = 4'd0; cfg_down = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("err_step_pulse", err_step, 1);
    check("err_step_busy", busy, 0);
    check("err_step_done", done, 0);
    @(negedge clk);
    check("err_step_clear", err_step, 0);

    // Repeat mode: 0,1,2,done,... then abort mid-run.
    cfg_start = 4'd0; cfg_limit = 4'd3; cfg_step = 4'd1; cfg_down = 1'b0;
    cfg_repeat = 1'b1; out_ready = 1'b1; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (t % 4 < 3) begin
        check("rpt_valid", out_valid, 1);
        check("rpt_value", out_value, t % 4);
        check("rpt_nodone", done, 0);
      end else begin
        check("rpt_done", done, 1);
        check("rpt_final", final_value, 3);
        check("rpt_novalid", out_valid, 0);
      end
      if (t == 9) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_final", final_value, 3);
    cfg_repeat = 1'b0;

    // Abort together with go in IDLE: abort wins.
    cfg_start = 4'd0; cfg_limit = 4'd8; cfg_step = 4'd1; go = 1'b1; abort = 1'b1;
    @(negedge clk);
    go = 1'b0; abort = 1'b0;
    check("abort_go_busy", busy, 0);

    // Reset in RUN while stalled.
    out_ready = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (2) @(negedge clk);
    check("stall_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_valid", out_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_value", out_value, 0);
    check("mrst_final", final_value, 0);
    check("mrst_done", done, 0);

    // Normal run after reset with a go ignored while busy.
    run_loop(4'd3, 4'd12, 4'd3, 1'b0, 0, 1'b1);

    // Randomised loops.
    for (int k = 0; k < 30; k++) begin
      run_loop(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/for_loop_counter.md
Name: for_loop_counter

Overview:
Hardware realisation of a parametrised for-loop iterator: configurable start, limit, signed-direction step, and repeat mode.
Emits one loop-index value per accepted valid/ready beat and reports the terminating index value on completion.
Wrap-around and zero-step are detected and terminate cleanly instead of looping forever.
Used as an index/address sequencer feeding downstream datapaths and as a reusable stimulus source for benches.

Parameters:
WIDTH, 4, bit width of index, start, limit, out_value, final_value
STEP_W, 4, bit width of unsigned step magnitude (STEP_W <= WIDTH)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
cfg_start  input  WIDTH  initial index; sampled on accepted go
cfg_limit  input  WIDTH  exclusive bound; sampled on accepted go
cfg_step  input  STEP_W  step magnitude; sampled on accepted go
cfg_down  input  1  0: count up, run while idx < limit; 1: count down, run while idx > limit
cfg_repeat  input  1  1: restart from start after each completion until abort
go  input  1  start request; accepted only in IDLE
abort  input  1  cancel; highest priority after rst
out_valid  output  1  current index valid
out_ready  input  1  downstream accepts index
out_value  output  WIDTH  current loop index
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse
final_value  output  WIDTH  index value that failed the loop condition; held until next done
wrapped  output  1  qualifies done: loop ended by carry/borrow out of WIDTH
err_step  output  1  one-cycle pulse: go accepted with cfg_step == 0

Behaviour:
- Reset (rst=1 at posedge): state IDLE. out_valid, busy, done, wrapped, err_step = 0. out_value, final_value = 0. Latched config = 0.
- States: IDLE, RUN, DONE.
- IDLE, go=1, step==0: err_step=1 next cycle; no done; stay IDLE.
- IDLE, go=1, step!=0: latch cfg_*; idx=start.
  - Loop condition true: -> RUN.
  - Loop condition false (zero-trip): -> DONE; final_value=start; wrapped=0.
- RUN:
  - out_valid=1, out_value=idx. Latency go->first out_valid = 1 cycle.
  - out_valid is held with out_value stable while out_ready=0.
  - On out_valid & out_ready, nxt = idx +/- step, computed in WIDTH+1 bits.
    - Carry (up) or borrow (down): -> DONE; final_value=nxt[WIDTH-1:0]; wrapped=1.
    - Else, condition false on nxt: -> DONE; final_value=nxt; wrapped=0.
    - Else: idx=nxt and stay in RUN. Back-to-back beats at one per cycle when ready is held high.
- DONE: one cycle, done=1, out_valid=0.
  - repeat=1: next state RUN with idx=start. A zero-trip repeat loops DONE->DONE, pulsing done every cycle.
  - repeat=0: -> IDLE.
- Comparisons are unsigned. Step is zero-extended to WIDTH+1.
- go while busy: ignored; latched config is not disturbed.
- abort=1 in any state: -> IDLE next cycle. out_valid=0, no done. final_value retains previous value.
- abort with go in the same cycle: abort wins.
- rst mid-loop: full reset values regardless of handshake state.
- wrapped is meaningful only while done=1. It is 0 otherwise.

Decomposition:
- Package for_loop_pkg:
  - state enum: IDLE, RUN, DONE.
  - struct loop_cfg_t: start, limit, step, down, repeat, parametrised by WIDTH/STEP_W via localparam defaults.
  - function loop_cond(idx, limit, down).
- One sub-module, loop_step_alu:
  - Purely combinational add/sub in WIDTH+1 bits.
  - Outputs nxt, carry/borrow flag, and continue flag.
  - Keeps the FSM free of arithmetic and is unit-testable in isolation.

Test Plan:
- WIDTH=4, up, start=2, limit=14, step=2, ready=1 -> out_value 2,4,6,8,10,12 on 6 consecutive cycles; done with final_value=14, wrapped=0.
- Same config with ready toggling 1,0,0,1,... -> out_value held stable while ready=0; same 6-value sequence; no value lost or duplicated.
- Up, start=10, limit=15, step=4 -> out_value 10,14; done, final_value=2, wrapped=1. Down, start=9, limit=2, step=3 -> 9,6,3; final_value=0, wrapped=0.
- Zero-trip start=5, limit=5 -> no out_valid; done on cycle after go; final_value=5. step=0 -> err_step pulse, busy stays 0.
- repeat=1, start=0, limit=3, step=1 -> 0,1,2, done, 0,1,2, done...; abort asserted mid-run -> out_valid=0 next cycle, IDLE, no done.
- rst asserted during RUN with out_ready=0 -> all outputs 0 next cycle. A subsequent go then runs normally; a go during busy is ignored.
